pipe_adder_flags: RTL and testbench



---
 rtl/pipe_adder_flags.sv | 121 ++++++++++++
 tb/tb_pipe_adder_flags.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder_flags.sv
// rtl/pipe_adder_flags.sv - skewed pipelined ripple-carry adder/subtractor with result flags
module pipe_adder_flags #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             sign,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);
    localparam int NSTG = WIDTH / CHUNK;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_c;
    logic             fin_v;
    logic             fin_amsb;
    logic             fin_bmsb;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & rst_n;
    assign b_eff    = sub ? ~input2 : input2;

    // Stage k holds the k+1 resolved low chunks plus the still-unadded upper chunks of A and B'.
    for (genvar k = 0; k < NSTG - 1; k++) begin : g_stg
        localparam int UW = WIDTH - (k + 1) * CHUNK;
        logic                     v_q, c_q, v_d, c_d;
        logic [(k+1)*CHUNK-1:0]   s_q, s_d;
        logic [UW-1:0]            a_q, b_q, a_d, b_d;
        logic [CHUNK:0]           part;

        if (k == 0) begin : g_head
            assign part = {1'b0, input1[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, sub};
            assign s_d  = part[CHUNK-1:0];
            assign a_d  = input1[WIDTH-1:CHUNK];
            assign b_d  = b_eff[WIDTH-1:CHUNK];
            assign v_d  = in_valid;
        end else begin : g_body
            assign part = {1'b0, g_stg[k-1].a_q[CHUNK-1:0]} + {1'b0, g_stg[k-1].b_q[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, g_stg[k-1].c_q};
            assign s_d  = {part[CHUNK-1:0], g_stg[k-1].s_q};
            assign a_d  = g_stg[k-1].a_q[UW+CHUNK-1:CHUNK];
            assign b_d  = g_stg[k-1].b_q[UW+CHUNK-1:CHUNK];
            assign v_d  = g_stg[k-1].v_q;
        end
        assign c_d = part[CHUNK];

        // Bubbles leave the data registers untouched; only the valid bit moves.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                if (v_d) begin
                    c_q <= c_d;
                    s_q <= s_d;
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    if (NSTG == 1) begin : g_single
        logic [WIDTH:0] full;
        assign full     = {1'b0, input1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        assign fin_sum  = full[WIDTH-1:0];
        assign fin_c    = full[WIDTH];
        assign fin_v    = in_valid;
        assign fin_amsb = input1[WIDTH-1];
        assign fin_bmsb = b_eff[WIDTH-1];
    end else begin : g_multi
        logic [CHUNK:0] top;
        assign top      = {1'b0, g_stg[NSTG-2].a_q} + {1'b0, g_stg[NSTG-2].b_q}
                        + {{CHUNK{1'b0}}, g_stg[NSTG-2].c_q};
        assign fin_sum  = {top[CHUNK-1:0], g_stg[NSTG-2].s_q};
        assign fin_c    = top[CHUNK];
        assign fin_v    = g_stg[NSTG-2].v_q;
        assign fin_amsb = g_stg[NSTG-2].a_q[CHUNK-1];
        assign fin_bmsb = g_stg[NSTG-2].b_q[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            parity    <= 1'b0;
            overflow  <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_v;
            if (fin_v) begin
                sum      <= fin_sum;
                carry    <= fin_c;
                sign     <= fin_sum[WIDTH-1];
                zero     <= (fin_sum == '0);
                parity   <= ~^fin_sum;
                overflow <= (fin_amsb == fin_bmsb) && (fin_sum[WIDTH-1] != fin_amsb);
            end
        end
    end
endmodule

// File: tb/tb_pipe_adder_flags.sv
// tb/tb_pipe_adder_flags.sv - randomized and directed bench for pipe_adder_flags
module tb_pipe_adder_flags;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [15:0] input1 = '0, input2 = '0, sum;
    logic        in_ready, out_valid, carry, sign, zero, parity, overflow;

    logic        v32 = 1'b0, ir32, ov32, c32, sg32, z32, p32, of32;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        v8 = 1'b0, ir8, ov8, c8, sg8, z8, p8, of8;
    logic [7:0]  a8 = '0, b8 = '0, s8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_adder_flags dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .input1(input1), .input2(input2), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .sign(sign), .zero(zero), .parity(parity), .overflow(overflow)
    );

    pipe_adder_flags #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .sub(1'b0),
        .input1(a32), .input2(b32), .out_valid(ov32), .out_ready(1'b1),
        .sum(s32), .carry(c32), .sign(sg32), .zero(z32), .parity(p32), .overflow(of32)
    );

    pipe_adder_flags #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .sub(1'b0),
        .input1(a8), .input2(b8), .out_valid(ov8), .out_ready(1'b1),
        .sum(s8), .carry(c8), .sign(sg8), .zero(z8), .parity(p8), .overflow(of8)
    );

    // Packed result: {overflow, parity, zero, sign, carry, sum}
    function automatic logic [20:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int          sa, sb, r;
        logic [16:0] full;
        logic [15:0] res;
        logic        c, ov;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            res = a - b;
            c   = (a >= b);
            r   = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            res  = full[15:0];
            c    = full[16];
            r    = sa + sb;
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, ~^res, (res == 16'h0), res[15], c, res};
    endfunction

    function automatic logic [20:0] observed();
        return {overflow, parity, zero, sign, carry, sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || observed() !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b flags/sum=%h, want 0/0", out_valid, observed());
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 0", in_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_reset: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_directed(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 input logic [20:0] want, input string name);
        int lat;
        out_ready = 1'b1;
        input1 = a; input2 = b; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d, want 4", name, lat);
        end
        checks++;
        if (observed() !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, observed(), want);
        end
        checks++;
        if (want !== model16(a, b, s)) begin
            errors++;
            $display("FAIL %s_model: model %h, want %h", name, model16(a, b, s), want);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [20:0] q[$];
        logic [20:0] snap, obs, exp;
        logic        stalled = 1'b0, hold = 1'b0;
        int          sent = 0, got = 0;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (!hold) begin
                in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
                input1 = 16'($urandom);
                input2 = 16'($urandom);
                sub = 1'($urandom);
            end
            #1;
            obs = observed();
            if (stalled) begin
                checks++;
                if (obs !== snap || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got %h valid=%b, want %h valid=1", obs, out_valid, snap);
                end
            end
            if (out_valid && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 21'h1FFFFF;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL stream_result_%0d: got %h, want %h", got, obs, exp);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                snap = obs;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model16(input1, input2, sub));
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 20 || q.size() !== 0) begin
            errors++;
            $display("FAIL stream_count: got %0d results (%0d pending), want 20 (0)", got, q.size());
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            input1 = 16'h1000 * 16'(i + 1); input2 = 16'h0011; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_fill: got out_valid=%b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || observed() !== 21'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: got valid=%b data=%h ready=%b, want 0/0/0",
                     out_valid, observed(), in_ready);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        input1 = 16'h0001; input2 = 16'h0002; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                seen++;
                checks++;
                if (observed() !== model16(16'h0001, 16'h0002, 1'b0)) begin
                    errors++;
                    $display("FAIL post_reset_result: got %h, want %h", observed(),
                             model16(16'h0001, 16'h0002, 1'b0));
                end
            end
            tick();
        end
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d results, want 1", seen);
        end
    endtask

    task automatic test_params();
        int lat;
        a32 = 32'h7FFFFFFF; b32 = 32'h1; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 4 || {of32, sg32, c32, z32, s32} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000}) begin
            errors++;
            $display("FAIL w32_c8: got lat=%0d of=%b sg=%b c=%b z=%b sum=%h, want 4 1 1 0 0 80000000",
                     lat, of32, sg32, c32, z32, s32);
        end
        checks++;
        if (p32 !== 1'b0) begin
            errors++;
            $display("FAIL w32_parity: got %b, want 0", p32);
        end
        a8 = 8'h7F; b8 = 8'h01; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1 || {of8, sg8, c8, z8, p8, s8} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL w8_c8: got valid=%b of=%b sg=%b c=%b z=%b p=%b sum=%h, want 1 1 1 0 0 0 80",
                     ov8, of8, sg8, c8, z8, p8, s8);
        end
        tick();
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL param_idle: got ov8=%b ir8=%b ir32=%b, want 0 1 1", ov8, ir8, ir32);
        end
    endtask

    initial begin
        test_reset();
        test_directed(16'hBFFF, 16'h8000, 1'b0, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3FFF}, "add_bfff_8000");
        test_directed(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000}, "add_ffff_0001");
        test_directed(16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE}, "sub_5_7");
        test_directed(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF}, "sub_8000_1");
        test_stream();
        test_reset_midflight();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
